// File: rtl/z_mips_pkg.sv
// Shared MIPS decode constants for the ID/EX stage.
// Opcodes, functs, instruction field positions and stage state encoding.
package z_mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FULL = 2'd1,
        ST_LU   = 2'd2
    } idex_st_e;

    // Instructions whose rt field is a source operand.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) ||
               (op == OP_BNE)   || (op == OP_SW);
    endfunction

endpackage

// File: rtl/z_fwd_mux.sv
// Per-operand forwarding select: EX/MEM, then MEM/WB, then register value.
// Register $0 is never forwarded.
module z_fwd_mux
    import z_mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [4:0]        src,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              exmem_wr,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wr,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic [DATA_W-1:0] y
);

    logic hit_ex;
    logic hit_wb;

    assign hit_ex = exmem_wr && (exmem_rd == src) && (src != REG_ZERO);
    assign hit_wb = memwb_wr && (memwb_rd == src) && (src != REG_ZERO);

    // Younger producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        y = reg_val;
        if (hit_ex) begin
            y = exmem_data;
        end else if (hit_wb) begin
            y = memwb_data;
        end
    end

endmodule

// File: rtl/z_idex_stage.sv
// Decode-to-execute register stage with forwarding and load-use bubbles.
// Optional macro Z_IDEX_STALL_CNT_EN adds a saturating stall_cnt output.
module z_idex_stage
    import z_mips_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LU_STALL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [DATA_W-1:0] id_ins,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [4:0]        id_shamt,
    input  logic              exmem_wr,
    input  logic [4:0]        exmem_rd,
    input  logic [DATA_W-1:0] exmem_data,
    input  logic              memwb_wr,
    input  logic [4:0]        memwb_rd,
    input  logic [DATA_W-1:0] memwb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [4:0]        shamt_out,
    output logic [DATA_W-1:0] ins_out
`ifdef Z_IDEX_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam logic [1:0] LU_INIT = 2'(LU_STALL - 1);

    idex_st_e          state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] ins_q, ins_d;
    logic [DATA_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic [4:0]        shamt_q, shamt_d;

    logic [5:0] h_op;
    logic [4:0] h_rs;
    logic [4:0] h_rt;
    logic [5:0] i_op;
    logic [4:0] i_rs;
    logic [4:0] i_rt;
    logic       lu_hit;
    logic       cap;

    assign h_op = ins_q[OP_MSB:OP_LSB];
    assign h_rs = ins_q[RS_MSB:RS_LSB];
    assign h_rt = ins_q[RT_MSB:RT_LSB];
    assign i_op = id_ins[OP_MSB:OP_LSB];
    assign i_rs = id_ins[RS_MSB:RS_LSB];
    assign i_rt = id_ins[RT_MSB:RT_LSB];

    z_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
        .src        (h_rs),
        .reg_val    (rs_q),
        .exmem_wr   (exmem_wr),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_wr   (memwb_wr),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .y          (a_out)
    );

    z_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
        .src        (h_rt),
        .reg_val    (rt_q),
        .exmem_wr   (exmem_wr),
        .exmem_rd   (exmem_rd),
        .exmem_data (exmem_data),
        .memwb_wr   (memwb_wr),
        .memwb_rd   (memwb_rd),
        .memwb_data (memwb_data),
        .y          (b_out)
    );

    // Load-use hazard: held lw writes a register the incoming op reads.
    always_comb begin
        lu_hit = 1'b0;
        if (id_valid && (state_q == ST_FULL) &&
            (h_op == OP_LW) && (h_rt != REG_ZERO)) begin
            lu_hit = (h_rt == i_rs) ||
                     (uses_rt(i_op) && (h_rt == i_rt));
        end
    end

    assign id_ready = !flush && !lu_hit &&
                      ((state_q != ST_FULL) || ex_ready) &&
                      (state_q != ST_LU);
    assign cap      = id_valid && id_ready;

    // Next-state and datapath register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ins_d   = ins_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        shamt_d = shamt_q;
        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = 2'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cap) state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (ex_ready) begin
                        if (lu_hit) begin
                            state_d = ST_LU;
                            cnt_d   = LU_INIT;
                        end else if (cap) begin
                            state_d = ST_FULL;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Latch forwarded values; producers may retire.
                        rs_d = a_out;
                        rt_d = b_out;
                    end
                end
                ST_LU: begin
                    if (cnt_q == 2'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (cap) begin
                ins_d   = id_ins;
                rs_d    = id_rs_data;
                rt_d    = id_rt_data;
                shamt_d = id_shamt;
            end
        end
    end

    // Stage state and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            ins_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            shamt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ins_q   <= ins_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            shamt_q <= shamt_d;
        end
    end

    assign ex_valid  = (state_q == ST_FULL);
    assign shamt_out = shamt_q;
    assign ins_out   = ins_q;

`ifdef Z_IDEX_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles decode is blocked; saturate instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_valid && !id_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
